// File: rtl/stage_mem_pkg.sv
// Shared types and constants for the stage_mem memory-access stage.
package stage_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/stage_mem_align.sv
// Sub-word lane steering: byte enables, store replication, load extension.
// Only present when MEM_SUBWORD_EN is defined.
`ifdef MEM_SUBWORD_EN
module mem_align
  import stage_mem_pkg::*;
#(
  parameter int unsigned WD_SIZE = 32
) (
  input  logic [2:0]         funct3,
  input  logic [1:0]         addr_lo,
  input  logic [WD_SIZE-1:0] wdata_in,
  input  logic [WD_SIZE-1:0] rdata_in,
  output logic [3:0]         be,
  output logic [WD_SIZE-1:0] wdata_out,
  output logic [WD_SIZE-1:0] rdata_out,
  output logic               misalign
);

  logic [15:0] lane;

  assign lane = 16'(rdata_in >> {addr_lo, 3'b000});

  always_comb begin
    be        = '1;
    wdata_out = wdata_in;
    rdata_out = rdata_in;
    misalign  = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: begin
        be        = 4'(4'b0001 << addr_lo);
        wdata_out = {(WD_SIZE/8){wdata_in[7:0]}};
        rdata_out = (funct3 == F3_LBU) ? WD_SIZE'(lane[7:0])
                                       : {{(WD_SIZE-8){lane[7]}}, lane[7:0]};
      end
      F3_LH, F3_LHU: begin
        misalign  = addr_lo[0];
        be        = 4'(4'b0011 << addr_lo);
        wdata_out = {(WD_SIZE/16){wdata_in[15:0]}};
        rdata_out = (funct3 == F3_LHU) ? WD_SIZE'(lane)
                                       : {{(WD_SIZE-16){lane[15]}}, lane};
      end
      default: misalign = |addr_lo;
    endcase
  end

endmodule
`endif

// File: rtl/stage_mem.sv
// Memory-access stage: issues ld/st over a req/ack port, stalls upstream, emits WB bundle.
// Optional sub-word access support under MEM_SUBWORD_EN.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int unsigned WD_SIZE       = 32,
  parameter int unsigned REG_ADDR_SIZE = 5,
  parameter int unsigned MEM_TIMEOUT   = MEM_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_i,
  input  logic [WD_SIZE-1:0]       alu_result_i,
  input  logic [WD_SIZE-1:0]       rs2_data_i,
  input  logic [REG_ADDR_SIZE-1:0] rd_i,
  input  logic                     ctrl_ld_i,
  input  logic                     ctrl_st_i,
  input  logic                     ctrl_reg_write_i,
  input  logic [2:0]               ctrl_funct3_i,
  output logic                     stall_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [WD_SIZE-1:0]       mem_addr_o,
  output logic [WD_SIZE-1:0]       mem_wdata_o,
  output logic [3:0]               mem_be_o,
  input  logic                     mem_ack_i,
  input  logic [WD_SIZE-1:0]       mem_rdata_i,
  output logic                     valid_o,
  output logic [WD_SIZE-1:0]       wb_data_o,
  output logic [REG_ADDR_SIZE-1:0] rd_o,
  output logic                     ctrl_reg_write_o,
  output logic                     misalign_o,
  output logic                     bus_err_o
);

  localparam int unsigned      CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  mem_state_t               state, state_n;
  logic [CNT_W-1:0]         cnt;
  logic                     ld_q, rw_q;
  logic [REG_ADDR_SIZE-1:0] rd_q;
  logic                     mem_op, last;
  logic [3:0]               be_c;
  logic [WD_SIZE-1:0]       wdata_c, rdata_c;
  logic                     mis_c;

  assign mem_op    = ctrl_ld_i | ctrl_st_i;
  assign last      = (cnt == CNT_LAST);
  assign mem_req_o = (state == ACCESS);

`ifdef MEM_SUBWORD_EN
  logic [1:0] addr_lo_q, addr_lo;
  logic [2:0] f3_q, f3;

  // One aligner serves both phases: live inputs at issue, latched ones for the load return.
  assign addr_lo = (state == IDLE) ? alu_result_i[1:0] : addr_lo_q;
  assign f3      = (state == IDLE) ? ctrl_funct3_i     : f3_q;

  mem_align #(.WD_SIZE(WD_SIZE)) u_align (
    .funct3    (f3),
    .addr_lo   (addr_lo),
    .wdata_in  (rs2_data_i),
    .rdata_in  (mem_rdata_i),
    .be        (be_c),
    .wdata_out (wdata_c),
    .rdata_out (rdata_c),
    .misalign  (mis_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_lo_q <= '0;
      f3_q      <= '0;
    end else if (state == IDLE && valid_i && mem_op) begin
      addr_lo_q <= alu_result_i[1:0];
      f3_q      <= ctrl_funct3_i;
    end
  end
`else
  logic unused_funct3;

  assign be_c          = '1;
  assign wdata_c       = rs2_data_i;
  assign rdata_c       = mem_rdata_i;
  assign mis_c         = |alu_result_i[1:0];
  assign unused_funct3 = ^ctrl_funct3_i;
`endif

  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i && mem_op && !mis_c) begin
          state_n = ACCESS;
          stall_o = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack_i || last) state_n = IDLE;
        else                   stall_o = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      ld_q             <= 1'b0;
      rw_q             <= 1'b0;
      rd_q             <= '0;
      mem_we_o         <= 1'b0;
      mem_addr_o       <= '0;
      mem_wdata_o      <= '0;
      mem_be_o         <= '0;
      valid_o          <= 1'b0;
      wb_data_o        <= '0;
      rd_o             <= '0;
      ctrl_reg_write_o <= 1'b0;
      misalign_o       <= 1'b0;
      bus_err_o        <= 1'b0;
    end else begin
      state      <= state_n;
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && !mem_op) begin
            valid_o          <= 1'b1;
            wb_data_o        <= alu_result_i;
            rd_o             <= rd_i;
            ctrl_reg_write_o <= ctrl_reg_write_i;
          end else if (valid_i && mis_c) begin
            valid_o          <= 1'b1;
            misalign_o       <= 1'b1;
            rd_o             <= rd_i;
            ctrl_reg_write_o <= 1'b0;
          end else if (valid_i) begin
            cnt         <= '0;
            ld_q        <= ctrl_ld_i & ~ctrl_st_i;
            rw_q        <= ctrl_reg_write_i;
            rd_q        <= rd_i;
            mem_we_o    <= ctrl_st_i;
            mem_addr_o  <= {alu_result_i[WD_SIZE-1:2], 2'b00};
            mem_wdata_o <= wdata_c;
            mem_be_o    <= be_c;
          end
        end
        ACCESS: begin
          // Ack is tested first so it wins over a coincident timeout.
          if (mem_ack_i) begin
            valid_o          <= 1'b1;
            rd_o             <= rd_q;
            ctrl_reg_write_o <= ld_q & rw_q;
            if (ld_q) wb_data_o <= rdata_c;
          end else if (last) begin
            valid_o          <= 1'b1;
            bus_err_o        <= 1'b1;
            rd_o             <= rd_q;
            ctrl_reg_write_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: vector table driven through a scoreboard plus corner sequences.
`timescale 1ns/1ps
module tb_stage_mem;
  import stage_mem_pkg::*;

  localparam int unsigned MEM_TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [31:0] alu_result_i, rs2_data_i, mem_rdata_i;
  logic [4:0]  rd_i;
  logic        ctrl_ld_i, ctrl_st_i, ctrl_reg_write_i, mem_ack_i;
  logic [2:0]  ctrl_funct3_i;
  logic        stall_o, mem_req_o, mem_we_o, valid_o, ctrl_reg_write_o, misalign_o, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;

  stage_mem #(.WD_SIZE(32), .REG_ADDR_SIZE(5), .MEM_TIMEOUT(MEM_TMO)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .alu_result_i(alu_result_i),
    .rs2_data_i(rs2_data_i), .rd_i(rd_i), .ctrl_ld_i(ctrl_ld_i), .ctrl_st_i(ctrl_st_i),
    .ctrl_reg_write_i(ctrl_reg_write_i), .ctrl_funct3_i(ctrl_funct3_i), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .valid_o(valid_o), .wb_data_o(wb_data_o), .rd_o(rd_o),
    .ctrl_reg_write_o(ctrl_reg_write_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st, rw;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, rdata;
    logic [4:0]  rd;
    int unsigned ack_n;     // ACCESS cycle in which ack arrives; 0 = never
    logic        req;
    logic [31:0] e_wb;
    logic        e_rw, e_mis, e_err, chk_data;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw, mis, err, chk_data;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ld, st, rw, input logic [2:0] f3,
                              input logic [31:0] addr, sdata, rdata, input logic [4:0] rd,
                              input int unsigned ack_n, input logic req, input logic [31:0] e_wb,
                              input logic e_rw, e_mis, e_err, chk_data,
                              input logic [3:0] e_be, input logic [31:0] e_wdata);
    vec_t v;
    v.ld = ld; v.st = st; v.rw = rw; v.f3 = f3; v.addr = addr; v.sdata = sdata;
    v.rdata = rdata; v.rd = rd; v.ack_n = ack_n; v.req = req; v.e_wb = e_wb;
    v.e_rw = e_rw; v.e_mis = e_mis; v.e_err = e_err; v.chk_data = chk_data;
    v.e_be = e_be; v.e_wdata = e_wdata;
    return v;
  endfunction

  // Scoreboard consumer: every valid_o pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_o) begin
        if (sbq.size() == 0) begin
          chk("valid_unexpected", {31'b0, valid_o}, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("wb_reg_write", {31'b0, ctrl_reg_write_o}, {31'b0, e.rw});
          chk("wb_misalign", {31'b0, misalign_o}, {31'b0, e.mis});
          chk("wb_bus_err", {31'b0, bus_err_o}, {31'b0, e.err});
          if (e.chk_data) begin
            chk("wb_data", wb_data_o, e.wb);
            chk("wb_rd", {27'b0, rd_o}, {27'b0, e.rd});
          end
        end
      end else if (misalign_o || bus_err_o) begin
        chk("pulse_without_valid", {30'b0, misalign_o, bus_err_o}, 32'd0);
      end
    end
  end

  task automatic idle_inputs();
    valid_i = 1'b0; ctrl_ld_i = 1'b0; ctrl_st_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit done;
    exp_t e;
    @(negedge clk);
    valid_i = 1'b1; alu_result_i = v.addr; rs2_data_i = v.sdata; rd_i = v.rd;
    ctrl_ld_i = v.ld; ctrl_st_i = v.st; ctrl_reg_write_i = v.rw; ctrl_funct3_i = v.f3;
    mem_rdata_i = v.rdata;
    e.wb = v.e_wb; e.rd = v.rd; e.rw = v.e_rw; e.mis = v.e_mis; e.err = v.e_err;
    e.chk_data = v.chk_data;
    sbq.push_back(e);
    #1 chk("stall_issue", {31'b0, stall_o}, {31'b0, v.req});
    if (v.req) begin
      done = 1'b0;
      for (int unsigned n = 1; n <= MEM_TMO + 2 && !done; n++) begin
        @(negedge clk);
        chk("access_req", {31'b0, mem_req_o}, 32'd1);
        chk("access_addr", mem_addr_o, {v.addr[31:2], 2'b00});
        chk("access_we", {31'b0, mem_we_o}, {31'b0, v.st});
        chk("access_be", {28'b0, mem_be_o}, {28'b0, v.e_be});
        chk("access_wdata", mem_wdata_o, v.e_wdata);
        mem_ack_i = (n == v.ack_n);
        #1 chk("stall_access", {31'b0, stall_o}, {31'b0, !(mem_ack_i || n == MEM_TMO)});
        if (mem_ack_i || n == MEM_TMO || !mem_req_o) done = 1'b1;
      end
      if (!done) chk("access_bound", 32'd0, 32'd1);
    end
    @(negedge clk);
    idle_inputs();
    chk("req_after", {31'b0, mem_req_o}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    alu_result_i = '0; rs2_data_i = '0; mem_rdata_i = '0; rd_i = '0;
    ctrl_reg_write_i = 1'b0; ctrl_funct3_i = '0;

    //         ld st rw f3      addr          sdata         rdata         rd ack req e_wb          rw mis err data be       wdata
    vecs.push_back(mk(0, 0, 1, F3_LW, 32'h0000_1234, 32'h0, 32'h0, 5, 0, 0, 32'h0000_1234, 1, 0, 0, 1, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 1, F3_LW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 7, 3, 1, 32'hDEAD_BEEF, 1, 0, 0, 1, 4'hF, 32'h0));
    vecs.push_back(mk(0, 1, 1, F3_SW, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 3, 1, 1, 32'h0, 0, 0, 0, 0, 4'hF, 32'hCAFE_F00D));
    vecs.push_back(mk(1, 0, 1, F3_LW, 32'h0000_0102, 32'h0, 32'h0, 4, 0, 0, 32'h0, 0, 1, 0, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 1, F3_LW, 32'h0000_0200, 32'h0, 32'h0, 6, 0, 1, 32'h0, 0, 0, 1, 0, 4'hF, 32'h0));
    vecs.push_back(mk(0, 0, 0, F3_LB, 32'hFFFF_FFFF, 32'h0, 32'h0, 31, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 1, F3_LW, 32'h0000_01FC, 32'h0, 32'h0BAD_F00D, 1, MEM_TMO, 1, 32'h0BAD_F00D, 1, 0, 0, 1, 4'hF, 32'h0));
    vecs.push_back(mk(0, 1, 0, F3_SW, 32'h0000_0101, 32'h1111_2222, 32'h0, 2, 0, 0, 32'h0, 0, 1, 0, 0, 4'h0, 32'h0));
`ifdef MEM_SUBWORD_EN
    vecs.push_back(mk(1, 0, 1, F3_LB, 32'h0000_0008, 32'h0, 32'h8000_0000, 8, 2, 1, 32'h0000_0000, 1, 0, 0, 1, 4'b0001, 32'h0));
    vecs.push_back(mk(1, 0, 1, F3_LB, 32'h0000_0103, 32'h0, 32'h8000_0000, 9, 1, 1, 32'hFFFF_FF80, 1, 0, 0, 1, 4'b1000, 32'h0));
    vecs.push_back(mk(1, 0, 1, F3_LBU, 32'h0000_0103, 32'h0, 32'h8000_0000, 10, 1, 1, 32'h0000_0080, 1, 0, 0, 1, 4'b1000, 32'h0));
    vecs.push_back(mk(0, 1, 0, F3_SB, 32'h0000_0101, 32'h0000_00AB, 32'h0, 11, 1, 1, 32'h0, 0, 0, 0, 0, 4'b0010, 32'hABAB_ABAB));
    vecs.push_back(mk(1, 0, 1, F3_LH, 32'h0000_0102, 32'h0, 32'h8001_0000, 12, 2, 1, 32'hFFFF_8001, 1, 0, 0, 1, 4'b1100, 32'h0));
    vecs.push_back(mk(1, 0, 1, F3_LHU, 32'h0000_0101, 32'h0, 32'h0, 13, 0, 0, 32'h0, 0, 1, 0, 0, 4'h0, 32'h0));
`else
    // funct3 is ignored without sub-word support: a "byte" load is a full word access.
    vecs.push_back(mk(1, 0, 1, F3_LB, 32'h0000_0008, 32'h0, 32'h8000_0000, 8, 2, 1, 32'h8000_0000, 1, 0, 0, 1, 4'hF, 32'h0));
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_be", {28'b0, mem_be_o}, 32'd0);
    chk("rst_wb", wb_data_o, 32'd0);
    chk("rst_rd", {27'b0, rd_o}, 32'd0);
    chk("rst_rw", {31'b0, ctrl_reg_write_o}, 32'd0);
    chk("rst_flags", {30'b0, misalign_o, bus_err_o}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Stray acks while idle (including right after a timeout) must not produce anything.
    mem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_ack_req", {31'b0, mem_req_o}, 32'd0);
      chk("stray_ack_valid", {31'b0, valid_o}, 32'd0);
      chk("stray_ack_stall", {31'b0, stall_o}, 32'd0);
    end
    mem_ack_i = 1'b0;

    // Reset mid-access abandons the transaction; the late ack is ignored.
    @(negedge clk);
    valid_i = 1'b1; ctrl_ld_i = 1'b1; alu_result_i = 32'h0000_0300;
    ctrl_reg_write_i = 1'b1; ctrl_funct3_i = F3_LW; rd_i = 5'd20;
    @(negedge clk);
    chk("rst_mid_req_before", {31'b0, mem_req_o}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_mid_valid", {31'b0, valid_o}, 32'd0);
    reset = 1'b0;
    idle_inputs();
    mem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ack_req", {31'b0, mem_req_o}, 32'd0);
      chk("late_ack_valid", {31'b0, valid_o}, 32'd0);
    end
    mem_ack_i = 1'b0;

    run_vec(vecs[0]);

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
Memory-access stage directly downstream of stage_alu. It consumes the ALU result (address or value), the store data, the destination register and the control bits. Loads and stores go to the data-memory port through a req/ack handshake; the stage stalls upstream until the access completes. It produces a registered write-back bundle for the WB stage.

Parameters:
WD_SIZE, 32, data/address width
REG_ADDR_SIZE, 5, destination register index width
MEM_TIMEOUT, 16, max cycles waiting for mem_ack_i before bus error

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
valid_i  in  1  upstream bundle valid
alu_result_i  in  WD_SIZE  effective address (ld/st) or result (others)
rs2_data_i  in  WD_SIZE  store data
rd_i  in  REG_ADDR_SIZE  destination register
ctrl_ld_i  in  1  load
ctrl_st_i  in  1  store
ctrl_reg_write_i  in  1  instruction writes rd
ctrl_funct3_i  in  3  access size/sign
stall_o  out  1  hold upstream pipeline registers
mem_req_o  out  1  memory request
mem_we_o  out  1  1=write
mem_addr_o  out  WD_SIZE  word-aligned address
mem_wdata_o  out  WD_SIZE  write data
mem_be_o  out  4  byte enables
mem_ack_i  in  1  access done; rdata valid same cycle
mem_rdata_i  in  WD_SIZE  read data
valid_o  out  1  WB bundle valid
wb_data_o  out  WD_SIZE  load data or passed ALU result
rd_o  out  REG_ADDR_SIZE  destination register
ctrl_reg_write_o  out  1  WB write enable
misalign_o  out  1  misaligned access (one-cycle, with valid_o)
bus_err_o  out  1  timeout (one-cycle, with valid_o)

Behaviour:
- Clock/reset: single clock clk; reset is synchronous and active-high.
- Reset values: all outputs 0. FSM in IDLE. Timeout counter 0.
- FSM states: IDLE, ACCESS.
- IDLE, valid_i=0: valid_o=0 next cycle.
- IDLE, non-memory op (valid_i & !ld & !st):
  - 1-cycle latency to WB.
  - Next cycle: valid_o=1, wb_data_o=alu_result_i, rd_o=rd_i, ctrl_reg_write_o=ctrl_reg_write_i.
  - stall_o=0.
- IDLE, ld or st:
  - If misaligned (word with addr[1:0]!=0, half with addr[0]!=0): no request.
  - Next cycle: valid_o=1, misalign_o=1, ctrl_reg_write_o=0.
  - Otherwise: register the request and go to ACCESS. stall_o=1 combinationally in this same cycle.
- ACCESS:
  - mem_req_o=1; mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o held stable.
  - stall_o=1 every cycle until the exit cycle.
  - Upstream holds its inputs while stall_o=1.
- ACCESS, mem_ack_i=1:
  - stall_o=0 that cycle; FSM returns to IDLE.
  - Next cycle: valid_o=1, mem_req_o=0.
  - Load: wb_data_o = aligned/extended mem_rdata_i; ctrl_reg_write_o=ctrl_reg_write_i.
  - Store: ctrl_reg_write_o=0.
- ACCESS, timeout: counter reaches MEM_TIMEOUT-1 without ack.
  - Drop mem_req_o; FSM returns to IDLE; stall_o=0 that cycle.
  - Next cycle: valid_o=1, bus_err_o=1, ctrl_reg_write_o=0.
  - Counter clears on entry to ACCESS.
- valid_o is a pulse: it is 0 in every cycle not listed above, including while in ACCESS.
- Addressing:
  - mem_addr_o = {addr[WD_SIZE-1:2],2'b00}.
  - Word access: mem_be_o=4'b1111.
- Edge cases:
  - mem_ack_i outside ACCESS is ignored.
  - ack and timeout in the same cycle: ack wins.
  - reset during ACCESS: mem_req_o=0 next cycle; the transaction is abandoned and a later ack is ignored.

Optional Feature:
- Macro: MEM_SUBWORD_EN.
- Defined: funct3 decodes LB/LH/LW/LBU/LHU and SB/SH/SW.
  - Byte enables from addr[1:0]; store data replicated across lanes.
  - Load data shifted from the addressed lane, then sign- or zero-extended.
- Undefined: every access is a word access; funct3 ignored; only word alignment checked.

Decomposition:
- PARAMS_pkg gets: mem_state_t enum (IDLE, ACCESS), F3_LB/LH/LW/LBU/LHU/SB/SH/SW constants, default MEM_TIMEOUT.
- Sub-module mem_align (combinational) generates mem_be_o, store-lane data and load extension; instantiated under MEM_SUBWORD_EN.

Test Plan:
- Non-memory op: alu_result_i=0x1234, rd_i=5, reg_write=1 -> next cycle valid_o=1, wb_data_o=0x1234, rd_o=5, stall_o never 1.
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> mem_addr_o=0x100 held for 3 cycles, stall_o=1 from issue until the ack cycle, then valid_o=1, wb_data_o=0xDEADBEEF.
- SW addr 0x40, data 0xCAFEF00D, ack after 1 cycle -> mem_we_o=1, mem_be_o=4'hF, mem_wdata_o=0xCAFEF00D; then valid_o=1, ctrl_reg_write_o=0.
- LW addr 0x102 -> no mem_req_o; next cycle misalign_o=1, valid_o=1, ctrl_reg_write_o=0.
- LW, never acked -> mem_req_o drops after 16 cycles, bus_err_o=1 for one cycle; a later ack is ignored.
- MEM_SUBWORD_EN: LB addr 0x103 with rdata 0x80000000 -> wb_data_o=0xFFFFFF80; LBU -> 0x00000080; SB addr 0x101 -> mem_be_o=4'b0010.
